// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

    function automatic logic [3:0] lane_en(input logic [1:0] size,
                                           input logic [1:0] a);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_WORD: m = 4'b1111;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: m = 4'b0001 << a;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  a,
                                             input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*a +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        r = 32'h0;
        case (size)
            SZ_WORD: r = word;
            SZ_HALF: r = {{16{sign & h[15]}}, h};
            SZ_BYTE: r = {{24{sign & b[7]}}, b};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a byte-enable write port and two
// registered read ports (access and debug).
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [31:0]   dbg_idx,
    output logic [31:0]   dbg_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] dbg_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Read registers hold old contents on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
            dbg_q   <= 32'h0;
        end else begin
            if (re) rdata_q <= mem[raddr];
            if (dbg_idx < 32'(DEPTH_WORDS)) dbg_q <= mem[dbg_idx[AW-1:0]];
            else                            dbg_q <= 32'h0;
        end
    end

    assign rdata    = rdata_q;
    assign dbg_data = dbg_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage load/store target with programmable latency and debug view.
// Optional DMEM_CNT_EN adds saturating completed load/store counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 2048,
    parameter int LATENCY     = 2,
    parameter int DBG_STRIDE  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
`ifdef DMEM_CNT_EN
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt,
`endif
    input  logic [1:0]  dbg_array,
    input  logic [5:0]  dbg_item,
    output logic [31:0] dbg_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, sign_q, err_q, ld_ok_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;

    logic        commit, bad;
    logic [31:0] wrep, arr_rdata, dbg_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (req_valid) begin
                state_d = S_WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);

    assign bad = (size_q == SZ_ILL)
               || ((size_q == SZ_HALF) && addr_q[0])
               || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))
               || (addr_q[31:2] >= 30'(DEPTH_WORDS));

    always_comb begin
        wrep = wdata_q;
        case (size_q)
            SZ_HALF: wrep = {2{wdata_q[15:0]}};
            SZ_BYTE: wrep = {4{wdata_q[7:0]}};
            default: wrep = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            err_q   <= 1'b0;
            ld_ok_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req_valid) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
            end
            if (commit) begin
                err_q   <= bad;
                ld_ok_q <= !we_q && !bad;
            end else if (state_q == S_RESP && resp_ready) begin
                err_q   <= 1'b0;
                ld_ok_q <= 1'b0;
            end
        end
    end

    assign dbg_idx = 32'(dbg_array) * 32'(DBG_STRIDE) + 32'(dbg_item);

    // Write is gated by rst so a commit edge that meets reset is dropped.
    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk      (clk),
        .rst      (rst),
        .we       (commit && we_q && !bad && !rst),
        .be       (lane_en(size_q, addr_q[1:0])),
        .waddr    (addr_q[AW+1:2]),
        .wdata    (wrep),
        .re       (commit && !we_q && !bad),
        .raddr    (addr_q[AW+1:2]),
        .rdata    (arr_rdata),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = err_q;
    assign resp_rdata = ld_ok_q
                      ? load_ext(arr_rdata, size_q, addr_q[1:0], sign_q)
                      : 32'h0;

`ifdef DMEM_CNT_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= 16'h0;
            wr_cnt_q <= 16'h0;
        end else if (state_q == S_RESP && resp_ready && !err_q) begin
            if (we_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (!we_q && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
